mem_iso_reconfig_seq: RTL and testbench
=======================================

# mem_iso_reconfig_seq

Sequencer that safely reprograms the AXI4-MM isolation core through its AXI-Lite control registers. On a single request it decouples the memory interface, polls until decoupling completes, optionally clears a latched protocol-verifier timeout, writes the four bandwidth-shaper token registers, and recouples. It acts as the AXI-Lite master in front of the isolation core's register file and replaces ad-hoc software sequencing.

## Interface
- TOKEN_COUNT_INT_WIDTH, 16, width of the init token fields
- TOKEN_COUNT_FRAC_WIDTH, 8, update token fields are FRAC+1 bits wide
- BASE_ADDR, 32'h0, byte base address of the isolation register file
- POLL_GAP, 4, idle cycles between decouple_done polls (≥0)
- POLL_LIMIT, 1024, maximum poll reads before watchdog abort (watchdog build only)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- req_valid / req_ready  in/out  1  request handshake
- req_aw_init, req_ar_init  in  INT_WIDTH  init tokens
- req_aw_upd, req_ar_upd  in  FRAC+1  update tokens
- req_clear_timeout  in  1  issue a timeout_error_clear write
- req_hold_decoupled  in  1  skip the final recouple write
- busy  out  1  high from request accept until done
- done  out  1  single-cycle completion pulse
- err  out  1  qualifies done; high means aborted
- err_code  out  2  00 ok, 01 SLVERR/DECERR resp, 10 watchdog; held until next accept
- m_awaddr[32], m_awvalid, m_awready, m_wdata[32], m_wstrb[4], m_wvalid, m_wready, m_bresp[2], m_bvalid, m_bready: AXI-Lite write master
- m_araddr[32], m_arvalid, m_arready, m_rdata[32], m_rresp[2], m_rvalid, m_rready: AXI-Lite read master

## Operation
- Register offsets: 0x00 decouple (wr bit0; rd bit1 = decouple_done), 0x04 verifier (bit0 clear), 0x08 AW init, 0x0C AW upd, 0x10 AR init, 0x14 AR upd.
- States: IDLE → DEC_WR → POLL_RD ↔ POLL_GAP → [CLR_WR] → AWI_WR → AWU_WR → ARI_WR → ARU_WR → [RECPL_WR] → DONE → IDLE. Any write or read state can also exit to ABORT → DONE.
- IDLE: req_ready=1. Accept captures all req_* fields into registers.
- DEC_WR writes 1 to 0x00.
- POLL_RD reads 0x00. If rdata[1]=1, advance. Otherwise go to POLL_GAP for POLL_GAP cycles, then re-read. When POLL_GAP=0, re-read immediately.
- CLR_WR (writes 1 to 0x04) runs only when req_clear_timeout is set.
- Token writes zero-extend the captured fields to 32 bits.
- RECPL_WR (writes 0 to 0x00) is skipped when req_hold_decoupled is set.
- Nonzero bresp or rresp → ABORT with err_code 01. No further writes are issued; the core is left decoupled.
- DONE: done=1 for one cycle. err=1 iff the sequence passed through ABORT.

## Timing
- Reset: busy, done, err, err_code, every m_*valid and m_bready/m_rready are 0. Address and data outputs are 0.
- Write beat: m_awvalid and m_wvalid rise together on the cycle after state entry. Each drops independently on its own ready. m_bready rises once both handshakes complete and drops after bvalid&bready. The next state is entered on the cycle after the B handshake.
- Read beat: m_arvalid is held until arready. m_rready rises after the AR handshake; m_rdata is sampled on rvalid&rready.
- m_wstrb is always 4'hF. m_awaddr and m_araddr are BASE_ADDR+offset.
- done fires on the cycle after the final B handshake. req_ready returns on the cycle after done.
- Reset asserted mid-transaction: every output clears on that edge and the FSM returns to IDLE. The slave-side state is not recovered.
- A req_valid held during busy is ignored; it is accepted when the FSM returns to IDLE.

## Configuration
- MEM_ISO_SEQ_WATCHDOG_EN defined: a poll counter increments on every POLL_RD read. When it reaches POLL_LIMIT with done still 0, the FSM goes to ABORT with err_code 10, and the core stays decoupled.
- Not defined: polling continues indefinitely. err_code 10 is never produced, and the counter logic is absent.

## Structure
- Package mem_iso_seq_pkg holds:
  - the register offset localparams
  - the state enum
  - the err_code constants (ERR_OK, ERR_RESP, ERR_WDOG)
- Sub-module mem_iso_axil_master: a single-beat AXI-Lite transaction engine.
  - Request side: start, is_read, addr, wdata.
  - Response side: ack, rdata, resp.
- The sequencer FSM drives mem_iso_axil_master.

## Test plan
- Nominal, with the slave model returning decouple_done on the 3rd poll. Tokens 0x0100/0x080/0x0200/0x040 → exact write order 0x00=1, 0x00 read ×3, 0x08, 0x0C, 0x10, 0x14, 0x00=0; done=1, err=0.
- clear_timeout=1 and hold_decoupled=1 → a write 0x04=1 appears after polling and there is no final 0x00=0 write.
- Slave returns bresp=2'b10 on the 0x0C write → no further transactions, done with err=1 and err_code=01.
- Watchdog build with POLL_LIMIT=8 and done never set → exactly 8 reads, then err_code=10. Non-watchdog build → still polling after 100 reads.
- aresetn low mid-AW handshake → all valids 0 on the next edge. A new request afterwards completes normally.
- Backpressure: awready delayed 5 cycles past wready → wvalid drops first, awvalid stays high until it is accepted, and exactly one B is consumed.

Source files
------------

// File: rtl/mem_iso_seq_pkg.sv
// rtl/mem_iso_seq_pkg.sv - register map, states and error codes for the isolation reconfig sequencer
package mem_iso_seq_pkg;

    localparam logic [31:0] OFF_DECOUPLE = 32'h00;
    localparam logic [31:0] OFF_VERIFIER = 32'h04;
    localparam logic [31:0] OFF_AW_INIT  = 32'h08;
    localparam logic [31:0] OFF_AW_UPD   = 32'h0C;
    localparam logic [31:0] OFF_AR_INIT  = 32'h10;
    localparam logic [31:0] OFF_AR_UPD   = 32'h14;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_RESP = 2'b01;
    localparam logic [1:0] ERR_WDOG = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEC_WR,
        S_POLL_RD,
        S_POLL_GAP,
        S_CLR_WR,
        S_AWI_WR,
        S_AWU_WR,
        S_ARI_WR,
        S_ARU_WR,
        S_RECPL_WR,
        S_ABORT,
        S_DONE
    } seq_state_t;

    // States that own exactly one AXI-Lite transaction.
    function automatic logic is_txn_state(input seq_state_t s);
        return s inside {S_DEC_WR, S_POLL_RD, S_CLR_WR, S_AWI_WR, S_AWU_WR,
                         S_ARI_WR, S_ARU_WR, S_RECPL_WR};
    endfunction

endpackage

// File: rtl/mem_iso_axil_master.sv
// rtl/mem_iso_axil_master.sv - single-beat AXI-Lite read/write transaction engine
module mem_iso_axil_master (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        is_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [31:0] r_awaddr, r_wdata, r_araddr;
    logic        w_addr_phase_end;

    // AW and W complete independently; B is only accepted once both have gone.
    assign w_addr_phase_end = (r_awvalid | r_wvalid) &
                              (!r_awvalid | m_awready) &
                              (!r_wvalid  | m_wready);

    // Channel valid/ready flags and captured address/data.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= 32'h0;
            r_wdata   <= 32'h0;
            r_araddr  <= 32'h0;
        end else begin
            if (start && !is_read) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= addr;
                r_wdata   <= wdata;
            end else begin
                if (r_awvalid && m_awready) r_awvalid <= 1'b0;
                if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
            end
            if (w_addr_phase_end)          r_bready <= 1'b1;
            else if (r_bready && m_bvalid) r_bready <= 1'b0;
            if (start && is_read) begin
                r_arvalid <= 1'b1;
                r_araddr  <= addr;
            end else if (r_arvalid && m_arready) begin
                r_arvalid <= 1'b0;
            end
            if (r_arvalid && m_arready)    r_rready <= 1'b1;
            else if (r_rready && m_rvalid) r_rready <= 1'b0;
        end
    end

    assign ack       = (r_bready & m_bvalid) | (r_rready & m_rvalid);
    assign resp      = r_rready ? m_rresp : m_bresp;
    assign rdata     = m_rdata;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

endmodule

// File: rtl/mem_iso_reconfig_seq.sv
// rtl/mem_iso_reconfig_seq.sv - decouple/poll/reprogram/recouple sequencer; MEM_ISO_SEQ_WATCHDOG_EN adds a poll watchdog
module mem_iso_reconfig_seq
    import mem_iso_seq_pkg::*;
#(
    parameter int          TOKEN_COUNT_INT_WIDTH  = 16,
    parameter int          TOKEN_COUNT_FRAC_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR              = 32'h0,
    parameter int          POLL_GAP               = 4,
    parameter int          POLL_LIMIT             = 1024
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [TOKEN_COUNT_INT_WIDTH-1:0]  req_aw_init,
    input  logic [TOKEN_COUNT_INT_WIDTH-1:0]  req_ar_init,
    input  logic [TOKEN_COUNT_FRAC_WIDTH:0]   req_aw_upd,
    input  logic [TOKEN_COUNT_FRAC_WIDTH:0]   req_ar_upd,
    input  logic                              req_clear_timeout,
    input  logic                              req_hold_decoupled,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [1:0]                        err_code,
    output logic [31:0]                       m_awaddr,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [31:0]                       m_wdata,
    output logic [3:0]                        m_wstrb,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    input  logic [1:0]                        m_bresp,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    output logic [31:0]                       m_araddr,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    input  logic [31:0]                       m_rdata,
    input  logic [1:0]                        m_rresp,
    input  logic                              m_rvalid,
    output logic                              m_rready
);
    seq_state_t                          r_state, w_next;
    logic                                r_issued;
    logic [TOKEN_COUNT_INT_WIDTH-1:0]    r_aw_init, r_ar_init;
    logic [TOKEN_COUNT_FRAC_WIDTH:0]     r_aw_upd, r_ar_upd;
    logic                                r_clear, r_hold;
    logic [1:0]                          r_err_code;
    logic [15:0]                         r_gap_cnt;
    logic                                w_start, w_is_read, w_ack;
    logic [31:0]                         w_addr, w_wdata, w_rdata;
    logic [1:0]                          w_resp;
    logic                                w_accept, w_resp_err, w_wdog_trip;
    logic                                w_unused_rdata;

    assign w_accept       = (r_state == S_IDLE) && req_valid;
    assign w_resp_err     = w_ack && (w_resp != 2'b00);
    assign w_unused_rdata = ^{w_rdata[31:2], w_rdata[0]};

`ifdef MEM_ISO_SEQ_WATCHDOG_EN
    logic [15:0] r_poll_cnt;

    // Count poll reads of the current request; trips on the POLL_LIMIT-th miss.
    always_ff @(posedge aclk) begin
        if (!aresetn || w_accept)             r_poll_cnt <= 16'h0;
        else if (r_state == S_POLL_RD && w_ack) r_poll_cnt <= r_poll_cnt + 16'h1;
    end

    assign w_wdog_trip = (r_poll_cnt == 16'(POLL_LIMIT - 1));
`else
    localparam int unused_poll_limit = POLL_LIMIT;
    assign w_wdog_trip = 1'b0;
`endif

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state, status outputs and the per-state transaction request.
    always_comb begin
        w_next    = r_state;
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        err       = (r_state == S_DONE) && (r_err_code != ERR_OK);
        w_start   = is_txn_state(r_state) && !r_issued;
        w_is_read = 1'b0;
        w_addr    = BASE_ADDR + OFF_DECOUPLE;
        w_wdata   = 32'h0;
        case (r_state)
            S_DEC_WR:   w_wdata = 32'h1;
            S_POLL_RD:  w_is_read = 1'b1;
            S_CLR_WR:   begin w_addr = BASE_ADDR + OFF_VERIFIER; w_wdata = 32'h1; end
            S_AWI_WR:   begin w_addr = BASE_ADDR + OFF_AW_INIT;  w_wdata = 32'(r_aw_init); end
            S_AWU_WR:   begin w_addr = BASE_ADDR + OFF_AW_UPD;   w_wdata = 32'(r_aw_upd);  end
            S_ARI_WR:   begin w_addr = BASE_ADDR + OFF_AR_INIT;  w_wdata = 32'(r_ar_init); end
            S_ARU_WR:   begin w_addr = BASE_ADDR + OFF_AR_UPD;   w_wdata = 32'(r_ar_upd);  end
            default:    ;
        endcase
        case (r_state)
            S_IDLE:     if (req_valid) w_next = S_DEC_WR;
            S_POLL_RD: begin
                if (w_ack) begin
                    if (w_resp_err)       w_next = S_ABORT;
                    else if (w_rdata[1])  w_next = r_clear ? S_CLR_WR : S_AWI_WR;
                    else if (w_wdog_trip) w_next = S_ABORT;
                    else if (POLL_GAP == 0) w_next = S_POLL_RD;
                    else                  w_next = S_POLL_GAP;
                end
            end
            S_POLL_GAP: if (r_gap_cnt == 16'(POLL_GAP - 1)) w_next = S_POLL_RD;
            S_ABORT:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default: begin
                if (w_resp_err) begin
                    w_next = S_ABORT;
                end else if (w_ack) begin
                    case (r_state)
                        S_DEC_WR:   w_next = S_POLL_RD;
                        S_CLR_WR:   w_next = S_AWI_WR;
                        S_AWI_WR:   w_next = S_AWU_WR;
                        S_AWU_WR:   w_next = S_ARI_WR;
                        S_ARI_WR:   w_next = S_ARU_WR;
                        S_ARU_WR:   w_next = r_hold ? S_DONE : S_RECPL_WR;
                        default:    w_next = S_DONE;
                    endcase
                end
            end
        endcase
    end

    // Request capture, one-shot transaction issue, poll gap timer and error code.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_issued   <= 1'b0;
            r_aw_init  <= '0;
            r_ar_init  <= '0;
            r_aw_upd   <= '0;
            r_ar_upd   <= '0;
            r_clear    <= 1'b0;
            r_hold     <= 1'b0;
            r_err_code <= ERR_OK;
            r_gap_cnt  <= 16'h0;
        end else begin
            if (w_ack)        r_issued <= 1'b0;
            else if (w_start) r_issued <= 1'b1;
            if (w_accept) begin
                r_aw_init  <= req_aw_init;
                r_ar_init  <= req_ar_init;
                r_aw_upd   <= req_aw_upd;
                r_ar_upd   <= req_ar_upd;
                r_clear    <= req_clear_timeout;
                r_hold     <= req_hold_decoupled;
                r_err_code <= ERR_OK;
            end else if (w_next == S_ABORT && r_state != S_ABORT) begin
                r_err_code <= w_resp_err ? ERR_RESP : ERR_WDOG;
            end
            r_gap_cnt <= (r_state == S_POLL_GAP) ? r_gap_cnt + 16'h1 : 16'h0;
        end
    end

    mem_iso_axil_master u_axil (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (w_start),
        .is_read   (w_is_read),
        .addr      (w_addr),
        .wdata     (w_wdata),
        .ack       (w_ack),
        .rdata     (w_rdata),
        .resp      (w_resp),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    assign err_code = r_err_code;

endmodule

// File: tb/tb_mem_iso_reconfig_seq.sv
// tb/tb_mem_iso_reconfig_seq.sv - directed self-checking bench for mem_iso_reconfig_seq
module tb_mem_iso_reconfig_seq;
    import mem_iso_seq_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LIMIT = 8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_clear_timeout, req_hold_decoupled;
    logic [15:0] req_aw_init, req_ar_init;
    logic [8:0]  req_aw_upd, req_ar_upd;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    always #5 aclk = ~aclk;

    mem_iso_reconfig_seq #(
        .TOKEN_COUNT_INT_WIDTH (16),
        .TOKEN_COUNT_FRAC_WIDTH(8),
        .BASE_ADDR             (BASE),
        .POLL_GAP              (4),
        .POLL_LIMIT            (LIMIT)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aw_init(req_aw_init), .req_ar_init(req_ar_init),
        .req_aw_upd(req_aw_upd), .req_ar_upd(req_ar_upd),
        .req_clear_timeout(req_clear_timeout), .req_hold_decoupled(req_hold_decoupled),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model configuration (written by the stimulus process only).
    int          aw_delay   = 0;
    int          done_after = 1;
    int          base_rd    = 0;
    logic [31:0] err_addr   = 32'hFFFF_FFFF;

    // Slave model observations (written by the slave process only).
    logic [63:0] log_q [0:511];
    int          log_n = 0, rd_cnt = 0, b_cnt = 0, w_first_cnt = 0;

    initial begin : slave
        logic [31:0] aw_addr_l, w_data_l;
        bit          aw_ok, w_ok, b_done, r_done, ar_ok;
        int          aw_wait;
        aw_ok = 0; w_ok = 0; b_done = 0; r_done = 0; ar_ok = 0; aw_wait = 0;
        aw_addr_l = '0; w_data_l = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(posedge aclk);
            if (m_awvalid && m_awready) begin aw_addr_l = m_awaddr; aw_ok = 1; end
            if (m_wvalid && m_wready)   begin w_data_l = m_wdata;   w_ok = 1;  end
            if (m_awvalid && !m_wvalid) w_first_cnt++;
            if (m_bvalid && m_bready) begin
                if (log_n < 512) log_q[log_n] = {7'b0, 1'b0, aw_addr_l[23:0], w_data_l};
                log_n++; b_cnt++; b_done = 1;
            end
            if (m_arvalid && m_arready) begin
                if (log_n < 512) log_q[log_n] = {7'b0, 1'b1, m_araddr[23:0], 32'h0};
                log_n++; rd_cnt++; ar_ok = 1;
            end
            if (m_rvalid && m_rready) r_done = 1;
            @(negedge aclk);
            if (!aresetn) begin
                aw_ok = 0; w_ok = 0; b_done = 0; r_done = 0; ar_ok = 0; aw_wait = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            end else begin
                if (b_done) begin m_bvalid = 0; b_done = 0; end
                if (r_done) begin m_rvalid = 0; r_done = 0; end
                if (aw_ok && w_ok && !m_bvalid) begin
                    m_bvalid = 1;
                    m_bresp  = (aw_addr_l == err_addr) ? 2'b10 : 2'b00;
                    aw_ok = 0; w_ok = 0;
                end
                if (ar_ok) begin
                    m_rvalid = 1;
                    m_rdata  = (done_after != 0 && (rd_cnt - base_rd) >= done_after) ? 32'h2 : 32'h0;
                    ar_ok = 0;
                end
                m_wready  = m_wvalid;
                m_awready = m_awvalid && (aw_wait >= aw_delay);
                aw_wait   = m_awvalid ? aw_wait + 1 : 0;
                m_arready = m_arvalid;
            end
        end
    end

    task automatic chk_seq(input string tag, input int base, input int idx,
                           input bit rd, input logic [31:0] off, input logic [31:0] data);
        logic [31:0] a;
        a = BASE + off;
        check($sformatf("%s_seq%0d", tag, idx), log_q[base + idx], {7'b0, rd, a[23:0], data});
    endtask

    task automatic send_req(input logic [15:0] awi, input logic [8:0] awu,
                            input logic [15:0] ari, input logic [8:0] aru,
                            input bit clr, input bit hold);
        @(negedge aclk);
        req_valid = 1; req_aw_init = awi; req_aw_upd = awu;
        req_ar_init = ari; req_ar_upd = aru;
        req_clear_timeout = clr; req_hold_decoupled = hold;
        @(negedge aclk);
        req_valid = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen,
                             output logic err_s, output logic [1:0] code_s);
        seen = 0; err_s = 1'bx; code_s = 2'bxx;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) begin seen = 1; err_s = err; code_s = err_code; end
            else @(negedge aclk);
        end
    endtask

    initial begin : global_timeout
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        bit          seen, saw_done, reached, saw_aw;
        logic        e;
        logic [1:0]  c;
        int          lb, bb, wf;
        aresetn = 0; req_valid = 0; req_aw_init = 0; req_ar_init = 0;
        req_aw_upd = 0; req_ar_upd = 0; req_clear_timeout = 0; req_hold_decoupled = 0;
        repeat (3) @(negedge aclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", {err, err_code}, 0);
        check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("rst_addr_data", {m_awaddr, m_wdata}, 0);
        check("rst_araddr", m_araddr, 0);
        aresetn = 1;
        @(negedge aclk);
        check("rst_req_ready", req_ready, 1);

        // Nominal: decouple_done seen on the third poll.
        done_after = 3; base_rd = rd_cnt; lb = log_n;
        send_req(16'h0100, 9'h080, 16'h0200, 9'h040, 0, 0);
        check("t1_busy", busy, 1);
        wait_done(1000, seen, e, c);
        check("t1_done_seen", seen, 1);
        check("t1_err", {e, c}, 0);
        @(negedge aclk);
        check("t1_done_pulse", done, 0);
        check("t1_req_ready", req_ready, 1);
        check("t1_count", log_n - lb, 9);
        chk_seq("t1", lb, 0, 0, OFF_DECOUPLE, 32'h1);
        for (int i = 1; i <= 3; i++) chk_seq("t1", lb, i, 1, OFF_DECOUPLE, 32'h0);
        chk_seq("t1", lb, 4, 0, OFF_AW_INIT, 32'h100);
        chk_seq("t1", lb, 5, 0, OFF_AW_UPD,  32'h080);
        chk_seq("t1", lb, 6, 0, OFF_AR_INIT, 32'h200);
        chk_seq("t1", lb, 7, 0, OFF_AR_UPD,  32'h040);
        chk_seq("t1", lb, 8, 0, OFF_DECOUPLE, 32'h0);
        check("t1_wstrb", m_wstrb, 4'hF);

        // Clear timeout, stay decoupled.
        done_after = 1; base_rd = rd_cnt; lb = log_n;
        send_req(16'hABCD, 9'h1FF, 16'h0001, 9'h000, 1, 1);
        wait_done(1000, seen, e, c);
        check("t2_done_seen", seen, 1);
        check("t2_err", {e, c}, 0);
        @(negedge aclk);
        check("t2_count", log_n - lb, 7);
        chk_seq("t2", lb, 0, 0, OFF_DECOUPLE, 32'h1);
        chk_seq("t2", lb, 1, 1, OFF_DECOUPLE, 32'h0);
        chk_seq("t2", lb, 2, 0, OFF_VERIFIER, 32'h1);
        chk_seq("t2", lb, 3, 0, OFF_AW_INIT, 32'hABCD);
        chk_seq("t2", lb, 4, 0, OFF_AW_UPD,  32'h1FF);
        chk_seq("t2", lb, 5, 0, OFF_AR_INIT, 32'h0001);
        chk_seq("t2", lb, 6, 0, OFF_AR_UPD,  32'h0);

        // SLVERR on the AW update write aborts the sequence.
        err_addr = BASE + OFF_AW_UPD; done_after = 2; base_rd = rd_cnt; lb = log_n;
        send_req(16'h1111, 9'h022, 16'h3333, 9'h044, 0, 0);
        wait_done(1000, seen, e, c);
        check("t3_done_seen", seen, 1);
        check("t3_err", {e, c}, {1'b1, ERR_RESP});
        repeat (20) @(negedge aclk);
        check("t3_count", log_n - lb, 5);
        chk_seq("t3", lb, 4, 0, OFF_AW_UPD, 32'h022);
        check("t3_quiet", {m_awvalid, m_wvalid, m_arvalid}, 0);
        check("t3_code_held", err_code, ERR_RESP);
        err_addr = 32'hFFFF_FFFF;

        // AW backpressure: awready five cycles after wready.
        aw_delay = 5; done_after = 1; base_rd = rd_cnt; lb = log_n; bb = b_cnt; wf = w_first_cnt;
        send_req(16'h0005, 9'h006, 16'h0007, 9'h008, 0, 0);
        wait_done(2000, seen, e, c);
        check("t4_done_seen", seen, 1);
        check("t4_err", {e, c}, 0);
        check("t4_b_count", b_cnt - bb, 6);
        check("t4_count", log_n - lb, 7);
        check("t4_w_first", w_first_cnt - wf, 30);
        chk_seq("t4", lb, 2, 0, OFF_AW_INIT, 32'h5);
        chk_seq("t4", lb, 6, 0, OFF_DECOUPLE, 32'h0);
        aw_delay = 0;

        // decouple_done never set.
        done_after = 0; base_rd = rd_cnt;
        send_req(16'h0009, 9'h00A, 16'h000B, 9'h00C, 0, 0);
`ifdef MEM_ISO_SEQ_WATCHDOG_EN
        wait_done(3000, seen, e, c);
        check("t5_done_seen", seen, 1);
        check("t5_err", {e, c}, {1'b1, ERR_WDOG});
        check("t5_reads", rd_cnt - base_rd, LIMIT);
`else
        saw_done = 0; reached = 0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge aclk);
            if (done) saw_done = 1;
            if (rd_cnt - base_rd >= 100) reached = 1;
        end
        check("t5_reached_100", reached, 1);
        check("t5_no_done", saw_done, 0);
        check("t5_busy", busy, 1);
`endif

        // Reset while AW is stalled, then a clean request.
        aresetn = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        aw_delay = 30;
        send_req(16'h0001, 9'h002, 16'h0003, 9'h004, 0, 0);
        saw_aw = 0;
        for (int i = 0; i < 20 && !saw_aw; i++) begin
            if (m_awvalid) saw_aw = 1;
            else @(negedge aclk);
        end
        check("t6_aw_pending", saw_aw, 1);
        aresetn = 0;
        @(negedge aclk);
        check("t6_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("t6_status", {busy, done, err, err_code}, 0);
        @(negedge aclk);
        aresetn = 1; aw_delay = 0; done_after = 2; base_rd = rd_cnt; lb = log_n;
        send_req(16'h0AAA, 9'h0BB, 16'h0CCC, 9'h0DD, 0, 0);
        wait_done(1000, seen, e, c);
        check("t6_done_seen", seen, 1);
        check("t6_err", {e, c}, 0);
        @(negedge aclk);
        check("t6_count", log_n - lb, 8);
        chk_seq("t6", lb, 0, 0, OFF_DECOUPLE, 32'h1);
        chk_seq("t6", lb, 3, 0, OFF_AW_INIT, 32'hAAA);
        chk_seq("t6", lb, 6, 0, OFF_AR_UPD, 32'h0DD);
        chk_seq("t6", lb, 7, 0, OFF_DECOUPLE, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
